// File: rtl/alu_result_fifo.sv
// First-word-fall-through result buffer behind the fixed-point ALU stage.
// Stores {overflow, data}, flags lost results and counts overflowed results.
module alu_result_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_overflow,
  input  logic                       i_ready,
  input  logic                       i_clr,
  output logic                       o_valid,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_overflow,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_drop,
  output logic [CNT_W-1:0]           o_ovf_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  logic [DATA_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;

  logic                push;
  logic                pop;
  logic [DATA_W:0]     head;

  assign o_valid = (count_q != '0);
  assign o_full  = (count_q == FULL_COUNT);
  assign pop     = o_valid & i_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign push    = i_valid & (~o_full | pop);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    drop_d    = drop_q;
    ovf_cnt_d = ovf_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      count_d = count_q + OCC_W'(1);
    else if (pop && !push) count_d = count_q - OCC_W'(1);

    // Clear takes priority, so a same-cycle drop or overflow is not recorded.
    if (i_clr) begin
      drop_d    = 1'b0;
      ovf_cnt_d = '0;
    end else begin
      if (i_valid && !push) drop_d = 1'b1;
      if (push && i_overflow && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      drop_q    <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      drop_q    <= drop_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; outputs are gated by occupancy instead.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_overflow, i_data};
  end

  assign head       = mem_q[rd_ptr_q];
  assign o_data     = o_valid ? head[DATA_W-1:0] : '0;
  assign o_overflow = o_valid ? head[DATA_W] : 1'b0;
  assign o_count    = count_q;
  assign o_drop     = drop_q;
  assign o_ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomised and directed bench for alu_result_fifo with a queue-based reference
// model and a negedge monitor comparing every visible output.
module tb_alu_result_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_overflow;
  logic       i_ready;
  logic       i_clr;

  logic       o_valid, o_overflow, o_full, o_drop;
  logic [7:0] o_data;
  logic [3:0] o_count;
  logic [7:0] o_ovf_cnt;

  logic       s_valid, s_overflow, s_full, s_drop;
  logic [7:0] s_data;
  logic [3:0] s_count;
  logic [1:0] s_ovf_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: FIFO contents as a queue, sticky drop, two counters.
  logic [8:0] exp_q[$];
  logic       m_drop;
  int         m_ovf;
  int         m_ovf2;

  alu_result_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_overflow(i_overflow), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(o_valid), .o_data(o_data), .o_overflow(o_overflow), .o_full(o_full),
    .o_count(o_count), .o_drop(o_drop), .o_ovf_cnt(o_ovf_cnt)
  );

  alu_result_fifo #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_overflow(i_overflow), .i_ready(i_ready), .i_clr(i_clr),
    .o_valid(s_valid), .o_data(s_data), .o_overflow(s_overflow), .o_full(s_full),
    .o_count(s_count), .o_drop(s_drop), .o_ovf_cnt(s_ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic ov,
                      input logic rdy, input logic c);
    i_valid    = v;
    i_data     = d;
    i_overflow = ov;
    i_ready    = rdy;
    i_clr      = c;
    @(posedge clk);
    #1;
  endtask

  // Reference model: updated on each rising edge from the rules of the buffer.
  initial begin
    exp_q.delete();
    m_drop = 1'b0;
    m_ovf  = 0;
    m_ovf2 = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_drop = 1'b0;
        m_ovf  = 0;
        m_ovf2 = 0;
      end else begin
        automatic bit pop  = (exp_q.size() != 0) && i_ready;
        automatic bit push = i_valid && ((exp_q.size() < DEPTH) || pop);
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back({i_overflow, i_data});
        if (i_clr) begin
          m_drop = 1'b0;
          m_ovf  = 0;
          m_ovf2 = 0;
        end else begin
          if (i_valid && !push) m_drop = 1'b1;
          if (push && i_overflow) begin
            if (m_ovf < 255) m_ovf++;
            if (m_ovf2 < 3) m_ovf2++;
          end
        end
      end
    end
  end

  // Monitor: compares every output against the model away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check("o_count", 32'(o_count), 32'(exp_q.size()));
        check("o_full", 32'(o_full), 32'(exp_q.size() == DEPTH));
        check("o_drop", 32'(o_drop), 32'(m_drop));
        check("o_ovf_cnt", 32'(o_ovf_cnt), 32'(m_ovf));
        check("sat_ovf_cnt", 32'(s_ovf_cnt), 32'(m_ovf2));
        check("sat_count", 32'(s_count), 32'(exp_q.size()));
        if (o_valid && exp_q.size() != 0)
          check("head", 32'({o_overflow, o_data}), 32'(exp_q[0]));
        else if (!o_valid)
          check("empty_head", 32'({o_overflow, o_data}), 32'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_data = '0; i_overflow = 1'b0; i_ready = 1'b0; i_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_drop", 32'(o_drop), 32'd0);
    check("rst_ovf", 32'(o_ovf_cnt), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Order and latency.
    step(1, 8'h11, 0, 0, 0);
    check("lat_valid", 32'(o_valid), 32'd1);
    check("lat_data", 32'(o_data), 32'h11);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    check("order_count", 32'(o_count), 32'd3);
    step(0, 8'h00, 0, 1, 0);
    check("order_2nd", 32'(o_data), 32'h22);
    step(0, 8'h00, 0, 1, 0);
    check("order_3rd", 32'(o_data), 32'h33);
    step(0, 8'h00, 0, 1, 0);
    check("order_empty_valid", 32'(o_valid), 32'd0);
    check("order_empty_count", 32'(o_count), 32'd0);

    // Full, drop and simultaneous push/pop at full.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i + 1), 0, 0, 0);
    check("full_flag", 32'(o_full), 32'd1);
    check("full_count", 32'(o_count), 32'd8);
    step(1, 8'h99, 0, 0, 0);
    check("drop_flag", 32'(o_drop), 32'd1);
    check("drop_count", 32'(o_count), 32'd8);
    step(1, 8'hAA, 0, 1, 0);
    check("pushpop_full_count", 32'(o_count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 7) check("aa_eighth", 32'(o_data), 32'hAA);
      step(0, 8'h00, 0, 1, 0);
    end
    step(0, 8'h00, 0, 0, 1);
    check("clr_drop", 32'(o_drop), 32'd0);

    // Overflow tracking and saturation of the narrow counter.
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    check("ovf3", 32'(o_ovf_cnt), 32'd3);
    check("ovf3_sat", 32'(s_ovf_cnt), 32'd3);
    for (int i = 3; i < 5; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
    check("ovf5", 32'(o_ovf_cnt), 32'd5);
    check("ovf5_sat", 32'(s_ovf_cnt), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("ovf_head_flag", 32'(o_overflow), 32'd1);
      step(0, 8'h00, 0, 1, 0);
    end

    // Clear beats a same-cycle overflowed push.
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h60 + i), logic'(i < 2), 0, 0);
    step(1, 8'h77, 0, 0, 0);
    check("pre_clr_drop", 32'(o_drop), 32'd1);
    check("pre_clr_ovf", 32'(o_ovf_cnt), 32'd2);
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'hC3, 1, 0, 1);
    check("clr_prio_drop", 32'(o_drop), 32'd0);
    check("clr_prio_ovf", 32'(o_ovf_cnt), 32'd0);
    check("clr_prio_count", 32'(o_count), 32'd8);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 7) begin
        check("clr_entry_data", 32'(o_data), 32'hC3);
        check("clr_entry_ovf", 32'(o_overflow), 32'd1);
      end
      step(0, 8'h00, 0, 1, 0);
    end

    // Wrap-around at one push and one pop per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1, 8'(i), 0, 1, 0);
      check("wrap_head", 32'(o_data), 32'(i));
    end
    step(0, 8'h00, 0, 1, 0);
    check("wrap_drained", 32'(o_count), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0, 0);
    check("pre_rst_count", 32'(o_count), 32'd4);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_count", 32'(o_count), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0), 8'($urandom), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 0, 1, 0);
    check("final_empty", 32'(o_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
